// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter in front of one UART transmitter.
// Ports: i_req_* per-requester byte streams, o_req_ready back-pressure,
// o_tx_* / i_tx_ready to the transmitter, o_grant/o_busy/o_timeout status.
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [8*NREQ-1:0] i_req_data,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ-1:0]   i_req_last,
  output logic [NREQ-1:0]   o_req_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_owner;
  logic [CW-1:0]   cnt;
  logic            timeout;

  logic [IW-1:0]   win;
  logic            locked;
  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            xfer;
  logic            expire;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = last_owner;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_owner) + i) % NREQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign locked    = (state == LOCKED);
  assign own_valid = i_req_valid[owner];
  assign own_last  = i_req_last[owner];
  assign own_data  = i_req_data[8*int'(owner) +: 8];
  assign xfer      = locked && own_valid && i_tx_ready;

  // cnt holds idle cycles already seen; this cycle makes it cnt+1.
  assign expire = locked && !own_valid &&
                  (int'(cnt) + 1 >= LOCK_TIMEOUT - 1);

  always_comb begin
    o_req_ready = '0;
    if (locked) begin
      o_req_ready[owner] = i_tx_ready;
    end
  end

  assign o_tx_valid = locked && own_valid;
  assign o_tx_data  = locked ? own_data : 8'h00;
  assign o_grant    = grant;
  assign o_busy     = locked;
  assign o_timeout  = timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      cnt        <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (|i_req_valid) begin
            state <= LOCKED;
            owner <= win;
            grant <= ONE << win;
          end
        end
        LOCKED: begin
          if (xfer && own_last) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= owner;
            cnt        <= '0;
          end else if (own_valid) begin
            cnt <= '0;
          end else if (expire) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= owner;
            cnt        <= '0;
            timeout    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, busy-timer transmitter,
// per-cycle output check against a behavioural model plus literal checks.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int LT   = 8;
  localparam int BUSY = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_data (req_data),
    .i_req_valid(req_valid),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  int n_pass = 0;
  int n_tot  = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         tx_busy = 0;
  bit         tx_hold = 0;
  int         log_owner[$];
  logic [7:0] log_data[$];
  bit         to_seen = 0;
  int         bad_ready = 0;

  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_run   = 0;
  bit m_to    = 0;
  bit m_live  = 0;

  function automatic void chk(input string name,
                              input logic [31:0] got,
                              input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  task automatic drive();
    req_valid[0] = (q0.size() > 0);
    req_valid[1] = (q1.size() > 0);
    req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    req_last[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
    req_last[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
    tx_ready = !tx_hold && (tx_busy == 0);
  endtask

  task automatic tick();
    logic [1:0] eg, er, v, l;
    logic [7:0] ed;
    logic       r, rs, acc0, acc1, txacc;
    @(negedge clk);
    if (m_live) begin
      eg = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
      er = tx_ready ? eg : 2'b00;
      ed = (m_owner < 0) ? 8'h00 :
           (m_owner == 0 ? req_data[7:0] : req_data[15:8]);
      chk("cyc_grant", 32'(grant), 32'(eg));
      chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
      chk("cyc_timeout", 32'(timeout), 32'(m_to));
      chk("cyc_ready", 32'(req_ready), 32'(er));
      chk("cyc_txvalid", 32'(tx_valid), 32'((eg & req_valid) != 0));
      chk("cyc_txdata", 32'(tx_data), 32'(ed));
    end
    acc0  = req_valid[0] & req_ready[0];
    acc1  = req_valid[1] & req_ready[1];
    txacc = tx_valid & tx_ready;
    if (grant == 2'b10 && req_ready[0]) bad_ready++;
    if (timeout) to_seen = 1;
    if (txacc) begin
      log_owner.push_back(acc1 ? 1 : 0);
      log_data.push_back(tx_data);
    end
    v = req_valid; l = req_last; r = tx_ready; rs = rst;
    @(posedge clk);
    #1;
    if (rs) begin
      m_owner = -1; m_last = NREQ - 1; m_run = 0; m_to = 0; m_live = 1;
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        for (int i = 1; i <= NREQ; i++) begin
          int k;
          k = (m_last + i) % NREQ;
          if (m_owner < 0 && v[k]) begin
            m_owner = k;
            m_run = 0;
          end
        end
      end else if (v[m_owner] && r) begin
        if (l[m_owner]) begin
          m_last = m_owner;
          m_owner = -1;
        end
        m_run = 0;
      end else if (v[m_owner]) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run >= LT - 1) begin
          m_to = 1; m_last = m_owner; m_owner = -1; m_run = 0;
        end
      end
    end
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    if (txacc) tx_busy = BUSY;
    else if (tx_busy > 0) tx_busy--;
    drive();
  endtask

  task automatic wait_log(input int n);
    int b = 0;
    while (log_data.size() < n && b < 300) begin
      tick();
      b++;
    end
    if (log_data.size() < n) chk("wait_log", 32'(log_data.size()), 32'(n));
  endtask

  task automatic idle();
    int b = 0;
    while ((tx_busy != 0 || m_owner >= 0 || q0.size() != 0 ||
            q1.size() != 0) && b < 500) begin
      tick();
      b++;
    end
    if (b >= 500) chk("idle_wait", 32'(b), 32'd0);
    log_data.delete();
    log_owner.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive();
    tick();
    tick();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_txvalid", 32'(tx_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    rst = 1'b0;

    // req0 sends "AB"
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b1, 8'h42});
    drive();
    tick();
    chk("t1_grant", 32'(grant), 32'd1);
    wait_log(2);
    chk("t1_b0", 32'(log_data[0]), 32'h41);
    chk("t1_b1", 32'(log_data[1]), 32'h42);
    chk("t1_release", 32'(grant), 32'd0);
    tick();
    chk("t1_count", 32'(log_data.size()), 32'd2);

    // contention after reset, then rotation
    idle();
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    q0.push_back({1'b1, 8'h43});
    q1.push_back({1'b1, 8'h44});
    drive();
    tick();
    chk("t2_first", 32'(grant), 32'd1);
    wait_log(1);
    chk("t2_gap", 32'(grant), 32'd0);
    tick();
    chk("t2_second", 32'(grant), 32'd2);
    wait_log(2);
    chk("t2_own0", 32'(log_owner[0]), 32'd0);
    chk("t2_own1", 32'(log_owner[1]), 32'd1);
    idle();
    q0.push_back({1'b1, 8'h45});
    q1.push_back({1'b1, 8'h46});
    drive();
    tick();
    chk("t2_rotate", 32'(grant), 32'd1);

    // req1 three-byte message while req0 waits
    idle();
    bad_ready = 0;
    q1.push_back({1'b0, 8'h31});
    q1.push_back({1'b0, 8'h32});
    q1.push_back({1'b1, 8'h33});
    drive();
    tick();
    chk("t3_grant", 32'(grant), 32'd2);
    q0.push_back({1'b1, 8'h58});
    drive();
    wait_log(4);
    chk("t3_b0", 32'({log_owner[0], log_data[0]}), 32'h131);
    chk("t3_b1", 32'({log_owner[1], log_data[1]}), 32'h132);
    chk("t3_b2", 32'({log_owner[2], log_data[2]}), 32'h133);
    chk("t3_b3", 32'({log_owner[3], log_data[3]}), 32'h058);
    chk("t3_noready0", 32'(bad_ready), 32'd0);

    // lock timeout
    idle();
    q0.push_back({1'b0, 8'h54});
    drive();
    tick();
    chk("t4_grant", 32'(grant), 32'd1);
    q1.push_back({1'b1, 8'h57});
    drive();
    wait_log(1);
    repeat (6) tick();
    chk("t4_early", 32'(timeout), 32'd0);
    chk("t4_held", 32'(grant), 32'd1);
    tick();
    chk("t4_pulse", 32'(timeout), 32'd1);
    chk("t4_drop", 32'(grant), 32'd0);
    tick();
    chk("t4_next", 32'(grant), 32'd2);
    chk("t4_once", 32'(timeout), 32'd0);
    wait_log(2);
    chk("t4_w", 32'(log_data[1]), 32'h57);

    // reset while locked with a byte pending
    idle();
    q1.push_back({1'b0, 8'h52});
    q1.push_back({1'b1, 8'h53});
    drive();
    tick();
    chk("t5_grant", 32'(grant), 32'd2);
    wait_log(1);
    q0.push_back({1'b1, 8'h55});
    rst = 1'b1;
    drive();
    tick();
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_txvalid", 32'(tx_valid), 32'd0);
    chk("t5_grant0", 32'(grant), 32'd0);
    chk("t5_nolog", 32'(log_data.size()), 32'd1);
    rst = 1'b0;
    drive();
    tick();
    chk("t5_prio", 32'(grant), 32'd1);

    // long stall with valid held: no timeout
    idle();
    to_seen = 0;
    tx_hold = 1;
    q0.push_back({1'b1, 8'h48});
    drive();
    tick();
    chk("t6_grant", 32'(grant), 32'd1);
    repeat (1000) tick();
    chk("t6_no_to", 32'(to_seen), 32'd0);
    chk("t6_held", 32'(grant), 32'd1);
    chk("t6_nolog", 32'(log_data.size()), 32'd0);
    tx_hold = 0;
    drive();
    wait_log(1);
    chk("t6_byte", 32'(log_data[0]), 32'h48);
    chk("t6_done", 32'(grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
